// File: rtl/int_pkg.sv
// Shared definitions for the interrupt acknowledge sequencer.
package int_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_LO = 2'd1,
    PUSH_HI = 2'd2,
    LOAD    = 2'd3
  } isq_state_e;

  // Interrupt source indices, in controller priority-scan order.
  localparam logic [2:0] SRC_EX0  = 3'd0;
  localparam logic [2:0] SRC_T0   = 3'd1;
  localparam logic [2:0] SRC_EX1  = 3'd2;
  localparam logic [2:0] SRC_T1   = 3'd3;
  localparam logic [2:0] SRC_S    = 3'd4;
  localparam logic [2:0] SRC_T2   = 3'd5;
  localparam logic [2:0] SRC_TXRX = 3'd6;

  localparam logic [7:0] VECT_BASE = 8'h03;
  localparam int         N_SRC     = 7;

  // Bit positions inside the nesting-level register.
  localparam int LVL_LO = 0;
  localparam int LVL_HI = 1;

  // Vector address for source v: vectors are spaced 8 bytes apart.
  function automatic logic [7:0] vect_addr(input logic [2:0] v);
    return VECT_BASE + {2'b00, v, 3'b000};
  endfunction

endpackage

// File: rtl/int_lvl_stack.sv
// Two-level interrupt nesting register: bit 0 = low-priority routine active,
// bit 1 = high-priority routine active. Pops the highest active level on RETI.
module int_lvl_stack
  import int_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       set_i,       // routine entered (LOAD cycle)
  input  logic       set_prio_i,  // priority of the routine being entered
  input  logic       pop_i,       // RETI pulse
  input  logic       chk_prio_i,  // priority of the candidate request
  output logic       permit_o,    // candidate may preempt the current level
  output logic [1:0] lvl_o,
  output logic       rdy_o        // a level was popped last cycle
);

  logic [1:0] lvl_q, lvl_d;
  logic       rdy_q, rdy_d;

  // Pop first, then set, so a RETI coinciding with LOAD behaves as a return
  // followed immediately by the new entry.
  always_comb begin
    lvl_d = lvl_q;
    rdy_d = 1'b0;
    if (pop_i) begin
      if (lvl_q[LVL_HI]) begin
        lvl_d[LVL_HI] = 1'b0;
      end else if (lvl_q[LVL_LO]) begin
        lvl_d[LVL_LO] = 1'b0;
      end
      rdy_d = (lvl_q != 2'b00);
    end
    if (set_i) begin
      lvl_d[set_prio_i] = 1'b1;
    end
  end

  // Nesting register and registered completion pulse.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lvl_q <= 2'b00;
      rdy_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      rdy_q <= rdy_d;
    end
  end

  // Nothing nests under a high routine; a low routine yields only to high.
  assign permit_o = (lvl_q == 2'b00) ||
                    (lvl_q[LVL_LO] && !lvl_q[LVL_HI] && chk_prio_i);
  assign lvl_o    = lvl_q;
  assign rdy_o    = rdy_q;

endmodule

// File: rtl/int_ack_seq.sv
// Interrupt acknowledge sequencer: accepts a request at an instruction
// boundary, pushes the return PC low byte then high byte, loads the vector.
//
// Stack handshake: isq_push_o is held high with stable isq_push_data_o until
// the CPU returns isq_stack_ack_i; a cycle with push and ack both high
// completes that byte, and the next byte is offered on the following cycle.
module int_ack_seq
  import int_pkg::*;
(
  input  logic        clk,
  input  logic        isq_rst_b_i,
  input  logic        isq_req_i,
  input  logic [2:0]  isq_vect_i,
  input  logic        isq_prio_i,
  input  logic        isq_cm_i,
  input  logic        isq_block_i,
  input  logic        isq_reti_i,
  input  logic [15:0] isq_pc_i,
  input  logic        isq_stack_ack_i,
  output logic        isq_hold_o,
  output logic        isq_push_o,
  output logic [7:0]  isq_push_data_o,
  output logic        isq_load_pc_o,
  output logic [15:0] isq_pc_o,
  output logic        isq_clr_o,
  output logic [2:0]  isq_vect_o,
  output logic        isq_na_o,
  output logic        isq_rdy_o,
  output logic [1:0]  isq_lvl_o
);

  isq_state_e  state_q, state_d;
  logic [2:0]  vect_q, vect_d;
  logic        prio_q, prio_d;
  logic [15:0] pc_q, pc_d;
  logic        na_q, na_d;
  logic        permit;
  logic        src_ok;

  assign src_ok = int'(isq_vect_i) < N_SRC;

  int_lvl_stack u_lvl (
    .clk        (clk),
    .rst_b      (isq_rst_b_i),
    .set_i      (state_q == LOAD),
    .set_prio_i (prio_q),
    .pop_i      (isq_reti_i),
    .chk_prio_i (isq_prio_i),
    .permit_o   (permit),
    .lvl_o      (isq_lvl_o),
    .rdy_o      (isq_rdy_o)
  );

  // Next-state and strobe decode; request inputs only matter in IDLE.
  always_comb begin
    state_d         = state_q;
    vect_d          = vect_q;
    prio_d          = prio_q;
    pc_d            = pc_q;
    na_d            = 1'b0;
    isq_hold_o      = 1'b0;
    isq_push_o      = 1'b0;
    isq_push_data_o = 8'h00;
    isq_load_pc_o   = 1'b0;
    isq_pc_o        = 16'h0000;
    isq_clr_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (isq_req_i && isq_cm_i) begin
          if (!isq_block_i && src_ok && permit) begin
            vect_d  = isq_vect_i;
            prio_d  = isq_prio_i;
            pc_d    = isq_pc_i;
            state_d = PUSH_LO;
          end else begin
            na_d = 1'b1;
          end
        end
      end
      PUSH_LO: begin
        isq_hold_o      = 1'b1;
        isq_push_o      = 1'b1;
        isq_push_data_o = pc_q[7:0];
        if (isq_stack_ack_i) state_d = PUSH_HI;
      end
      PUSH_HI: begin
        isq_hold_o      = 1'b1;
        isq_push_o      = 1'b1;
        isq_push_data_o = pc_q[15:8];
        if (isq_stack_ack_i) state_d = LOAD;
      end
      LOAD: begin
        isq_hold_o    = 1'b1;
        isq_load_pc_o = 1'b1;
        isq_clr_o     = 1'b1;
        isq_pc_o      = {8'h00, vect_addr(vect_q)};
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request context and the not-accepted pulse.
  always_ff @(posedge clk or negedge isq_rst_b_i) begin
    if (!isq_rst_b_i) begin
      state_q <= IDLE;
      vect_q  <= 3'd0;
      prio_q  <= 1'b0;
      pc_q    <= 16'h0000;
      na_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vect_q  <= vect_d;
      prio_q  <= prio_d;
      pc_q    <= pc_d;
      na_q    <= na_d;
    end
  end

  assign isq_vect_o = vect_q;
  assign isq_na_o   = na_q;

endmodule

// File: tb/tb_int_ack_seq.sv
// Directed bench for int_ack_seq: a vector table for the main flows plus
// hand-written sequences for stack back-pressure and mid-sequence reset.
module tb_int_ack_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, prio, cm, blk, reti, ack;
  logic [2:0]  vect;
  logic [15:0] pc;
  logic        hold, push, load, clr, na, rdy;
  logic [7:0]  pdata;
  logic [15:0] pc_o;
  logic [2:0]  vect_o;
  logic [1:0]  lvl;

  typedef struct {
    logic        req;
    logic [2:0]  vect;
    logic        prio;
    logic        cm;
    logic        blk;
    logic        reti;
    logic        ack;
    logic [15:0] pc;
    logic [34:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [34:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // Clock / reset block.
  always #5 clk = ~clk;

  int_ack_seq dut (
    .clk             (clk),
    .isq_rst_b_i     (rst_n),
    .isq_req_i       (req),
    .isq_vect_i      (vect),
    .isq_prio_i      (prio),
    .isq_cm_i        (cm),
    .isq_block_i     (blk),
    .isq_reti_i      (reti),
    .isq_pc_i        (pc),
    .isq_stack_ack_i (ack),
    .isq_hold_o      (hold),
    .isq_push_o      (push),
    .isq_push_data_o (pdata),
    .isq_load_pc_o   (load),
    .isq_pc_o        (pc_o),
    .isq_clr_o       (clr),
    .isq_vect_o      (vect_o),
    .isq_na_o        (na),
    .isq_rdy_o       (rdy),
    .isq_lvl_o       (lvl)
  );

  // Pack an output bundle: hold push data load pc clr vect na rdy lvl.
  function automatic logic [34:0] pk(input logic h, input logic p, input logic [7:0] d,
                                     input logic l, input logic [15:0] a, input logic c,
                                     input logic [2:0] v, input logic n, input logic r,
                                     input logic [1:0] lv);
    return {h, p, d, l, a, c, v, n, r, lv};
  endfunction

  // Idle-state bundle: only vect_o, na, rdy and lvl may be non-zero.
  function automatic logic [34:0] idl(input logic [2:0] v, input logic n, input logic r,
                                      input logic [1:0] lv);
    return pk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, v, n, r, lv);
  endfunction

  function automatic logic [34:0] act();
    return pk(hold, push, pdata, load, pc_o, clr, vect_o, na, rdy, lvl);
  endfunction

  task automatic check(input string name, input logic [34:0] exp);
    logic [34:0] got;
    got = act();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got hold=%b push=%b data=%h load=%b pc=%h clr=%b vect=%0d na=%b rdy=%b lvl=%b, expected %h (got %h)",
               name, hold, push, pdata, load, pc_o, clr, vect_o, na, rdy, lvl, exp, got);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [2:0] v, input logic p, input logic c,
                       input logic b, input logic rt, input logic a, input logic [15:0] pcv);
    req = r; vect = v; prio = p; cm = c; blk = b; reti = rt; ack = a; pc = pcv;
  endtask

  task automatic add(input logic r, input logic [2:0] v, input logic p, input logic c,
                     input logic b, input logic rt, input logic a, input logic [15:0] pcv,
                     input logic [34:0] e);
    vec_t t;
    t.req = r; t.vect = v; t.prio = p; t.cm = c; t.blk = b; t.reti = rt; t.ack = a;
    t.pc = pcv; t.exp = e;
    vecs.push_back(t);
  endtask

  initial begin
    int loads;
    int holds;
    rst_n = 1'b0;
    drive(0, 3'd0, 0, 0, 0, 0, 0, 16'h0000);

    // Reset state.
    tick();
    tick();
    check("reset", idl(3'd0, 0, 0, 2'b00));
    rst_n = 1'b1;

    // Table: inputs held for one cycle, expected outputs after that edge.
    // Low request vect 2, ack always high.
    add(1, 3'd2, 0, 1, 0, 0, 1, 16'h1234, pk(1, 1, 8'h34, 0, 16'h0000, 0, 3'd2, 0, 0, 2'b00));
    add(0, 3'd0, 0, 0, 0, 0, 1, 16'h1234, pk(1, 1, 8'h12, 0, 16'h0000, 0, 3'd2, 0, 0, 2'b00));
    add(0, 3'd0, 0, 0, 0, 0, 1, 16'h1234, pk(1, 0, 8'h00, 1, 16'h0013, 1, 3'd2, 0, 0, 2'b00));
    add(0, 3'd0, 0, 0, 0, 0, 1, 16'h0000, idl(3'd2, 0, 0, 2'b01));
    // Low request while low active: refused. High vect 6 nests.
    add(1, 3'd1, 0, 1, 0, 0, 1, 16'h1111, idl(3'd2, 1, 0, 2'b01));
    add(1, 3'd6, 1, 1, 0, 0, 1, 16'hABCD, pk(1, 1, 8'hCD, 0, 16'h0000, 0, 3'd6, 0, 0, 2'b01));
    add(0, 3'd0, 0, 0, 0, 0, 1, 16'hABCD, pk(1, 1, 8'hAB, 0, 16'h0000, 0, 3'd6, 0, 0, 2'b01));
    add(0, 3'd0, 0, 0, 0, 0, 1, 16'h0000, pk(1, 0, 8'h00, 1, 16'h0033, 1, 3'd6, 0, 0, 2'b01));
    add(0, 3'd0, 0, 0, 0, 0, 1, 16'h0000, idl(3'd6, 0, 0, 2'b11));
    // Both levels active: high refused; three RETIs.
    add(1, 3'd3, 1, 1, 0, 0, 1, 16'h0000, idl(3'd6, 1, 0, 2'b11));
    add(0, 3'd0, 0, 0, 0, 1, 1, 16'h0000, idl(3'd6, 0, 1, 2'b01));
    add(0, 3'd0, 0, 0, 0, 1, 1, 16'h0000, idl(3'd6, 0, 1, 2'b00));
    add(0, 3'd0, 0, 0, 0, 1, 1, 16'h0000, idl(3'd6, 0, 0, 2'b00));
    // Blocked boundary refused, next boundary accepted.
    add(1, 3'd4, 0, 1, 1, 0, 1, 16'h5678, idl(3'd6, 1, 0, 2'b00));
    add(1, 3'd4, 0, 1, 0, 0, 1, 16'h5678, pk(1, 1, 8'h78, 0, 16'h0000, 0, 3'd4, 0, 0, 2'b00));
    add(0, 3'd0, 0, 0, 0, 0, 1, 16'h5678, pk(1, 1, 8'h56, 0, 16'h0000, 0, 3'd4, 0, 0, 2'b00));
    add(0, 3'd0, 0, 0, 0, 0, 1, 16'h0000, pk(1, 0, 8'h00, 1, 16'h0023, 1, 3'd4, 0, 0, 2'b00));
    add(0, 3'd0, 0, 0, 0, 0, 1, 16'h0000, idl(3'd4, 0, 0, 2'b01));
    // Request off the boundary is neither taken nor refused.
    add(1, 3'd5, 1, 0, 0, 0, 1, 16'h0000, idl(3'd4, 0, 0, 2'b01));
    add(0, 3'd0, 0, 0, 0, 1, 1, 16'h0000, idl(3'd4, 0, 1, 2'b00));
    // Out-of-range source index refused.
    add(1, 3'd7, 1, 1, 0, 0, 1, 16'h0000, idl(3'd4, 1, 0, 2'b00));
    add(0, 3'd0, 0, 0, 0, 0, 1, 16'h0000, idl(3'd4, 0, 0, 2'b00));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].vect, vecs[i].prio, vecs[i].cm, vecs[i].blk,
            vecs[i].reti, vecs[i].ack, vecs[i].pc);
      exp_q.push_back(vecs[i].exp);
      tick();
      check($sformatf("vec%0d", i), exp_q.pop_front());
    end

    // Stack ack withheld for three cycles in PUSH_LO.
    drive(1, 3'd5, 0, 1, 0, 0, 0, 16'h9A5C);
    tick();
    check("dly_lo0", pk(1, 1, 8'h5C, 0, 16'h0000, 0, 3'd5, 0, 0, 2'b00));
    drive(0, 3'd0, 0, 0, 0, 0, 0, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("dly_lo%0d", i), pk(1, 1, 8'h5C, 0, 16'h0000, 0, 3'd5, 0, 0, 2'b00));
    end
    ack = 1'b1;
    loads = 0;
    holds = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) check("dly_hi", pk(1, 1, 8'h9A, 0, 16'h0000, 0, 3'd5, 0, 0, 2'b00));
      if (load) loads++;
      if (hold) holds++;
    end
    check_int("dly_loads", loads, 1);
    check_int("dly_holds", holds, 2);
    check("dly_end", idl(3'd5, 0, 0, 2'b01));

    // Reset in PUSH_HI while a low routine is active.
    drive(1, 3'd0, 1, 1, 0, 0, 1, 16'h4321);
    tick();
    check("rst_lo", pk(1, 1, 8'h21, 0, 16'h0000, 0, 3'd0, 0, 0, 2'b01));
    drive(0, 3'd0, 0, 0, 0, 0, 1, 16'h0000);
    tick();
    check("rst_hi", pk(1, 1, 8'h43, 0, 16'h0000, 0, 3'd0, 0, 0, 2'b01));
    #1 rst_n = 1'b0;
    #1 check("rst_async", idl(3'd0, 0, 0, 2'b00));
    tick();
    check("rst_held", idl(3'd0, 0, 0, 2'b00));
    rst_n = 1'b1;
    drive(1, 3'd1, 0, 1, 0, 0, 1, 16'h0102);
    tick();
    check("post_lo", pk(1, 1, 8'h02, 0, 16'h0000, 0, 3'd1, 0, 0, 2'b00));
    drive(0, 3'd0, 0, 0, 0, 0, 1, 16'h0000);
    tick();
    check("post_hi", pk(1, 1, 8'h01, 0, 16'h0000, 0, 3'd1, 0, 0, 2'b00));
    tick();
    check("post_load", pk(1, 0, 8'h00, 1, 16'h000B, 1, 3'd1, 0, 0, 2'b00));
    reti = 1'b1;
    tick();
    check("post_idle", idl(3'd1, 0, 0, 2'b01));
    tick();
    check("post_reti", idl(3'd1, 0, 1, 2'b00));
    reti = 1'b0;

    // Final report.
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_ack_seq.md
# int_ack_seq

Interrupt acknowledge sequencer between the INTERRUPT controller and the CPU core. It accepts a pending request only at an instruction boundary and only if its priority beats the active nesting level. It then stalls fetch, pushes the return PC to the stack in two byte writes, and loads the vector address. It tracks two-level nesting, and on RETI pops the nesting level and signals routine completion back to the controller.

## Interface
- VECT_BASE, 8'h03, address of vector 0; vector n = VECT_BASE + 8·n
- N_SRC, 7, number of valid sources (EX0, T0, EX1, T1, S, T2, TXRX)

Ports:
- clk  in  1  clock, rising edge
- isq_rst_b_i  in  1  reset, asynchronous, active-low
- isq_req_i  in  1  controller has a pending, enabled request
- isq_vect_i  in  3  index of the winning request (0..6)
- isq_prio_i  in  1  priority of the winning request, 1 = high
- isq_cm_i  in  1  last machine cycle of the current instruction
- isq_block_i  in  1  current instruction is RETI or writes IE/IP; acceptance forbidden
- isq_reti_i  in  1  RETI executed, one-cycle pulse
- isq_pc_i  in  16  return PC (next instruction address)
- isq_stack_ack_i  in  1  CPU completed the requested stack write
- isq_hold_o  out  1  stall CPU fetch/execute
- isq_push_o  out  1  stack write request
- isq_push_data_o  out  8  byte to push
- isq_load_pc_o  out  1  load isq_pc_o into the PC, one-cycle pulse
- isq_pc_o  out  16  vector address
- isq_clr_o  out  1  clear the serviced flag, one-cycle pulse (with isq_vect_o)
- isq_vect_o  out  3  vector being serviced
- isq_na_o  out  1  request seen at boundary but not accepted, one-cycle pulse
- isq_rdy_o  out  1  routine finished, one-cycle pulse (to controller int_rdy_i)
- isq_lvl_o  out  2  active levels: [0] low in service, [1] high in service

## Operation
- States: IDLE, PUSH_LO, PUSH_HI, LOAD.
- Acceptance in IDLE requires all of: isq_req_i, isq_cm_i, !isq_block_i, isq_vect_i < N_SRC, and level permits. Level permits when lvl==00, or when lvl[0] is set, lvl[1] is clear, and prio=1. It never permits when lvl[1] is set.
- Accept: latch vect, prio and pc, then go to PUSH_LO.
- Reject while req and cm are high: isq_na_o pulses and the state stays IDLE.
- PUSH_LO: push_o=1, data=pc[7:0]. Hold until stack_ack, then go to PUSH_HI.
- PUSH_HI: push_o=1, data=pc[15:8]. Hold until stack_ack, then go to LOAD.
- LOAD, one cycle: load_pc_o=1, pc_o={8'h00, VECT_BASE+8·vect}, clr_o=1, set lvl[prio]. Then go to IDLE.
- isq_hold_o=1 in PUSH_LO, PUSH_HI and LOAD.
- RETI, processed in any state:
  - If lvl[1] is set, clear lvl[1]; otherwise if lvl[0] is set, clear lvl[0].
  - isq_rdy_o pulses next cycle only if a level was cleared.
  - RETI with lvl==00 is ignored: no rdy.
- Same cycle as LOAD: the RETI clear applies first, then the LOAD set.
- Inputs other than isq_reti_i are ignored outside IDLE.
- isq_pc_o, isq_vect_o and isq_push_data_o are held from the latched values and are valid whenever their strobes are high.

## Timing
- Reset: state IDLE, lvl=00, all outputs 0. Asserting reset mid-sequence aborts immediately; no partial push completes.
- Acceptance cycle T (IDLE): hold and push rise at T+1.
- Minimum service with stack_ack every cycle:
  - PUSH_LO at T+1
  - PUSH_HI at T+2
  - LOAD at T+3
  - IDLE at T+4
  - 3 hold cycles total
- stack_ack in the same cycle as push completes that byte; the next push starts on the following cycle.
- isq_na_o and isq_rdy_o are registered, one cycle after the causing input.
- isq_clr_o is coincident with isq_load_pc_o.

## Structure
- Shared package int_pkg:
  - state enum (IDLE, PUSH_LO, PUSH_HI, LOAD)
  - source index constants (SRC_EX0=0 … SRC_TXRX=6)
  - VECT_BASE, N_SRC
  - level bit positions LVL_LO=0, LVL_HI=1
- Sub-module int_lvl_stack: 2-bit nesting register with set(prio), pop-highest and permit(prio) outputs. It drives isq_lvl_o and the rdy pulse.

## Test plan
- lvl=00; req, vect=2, prio=0, cm with ack tied high; pc=16'h1234 -> pushes 34 then 12; LOAD pc_o=16'h0013; clr_o and vect_o=2; lvl=01; hold high 3 cycles.
- lvl=01; request prio=0 at cm -> na pulse, no hold. Request prio=1, vect=6 -> accepted, pc_o=16'h0033, lvl=11.
- lvl=11; prio=1 request at cm -> na. RETI -> lvl=01, rdy pulse. RETI -> lvl=00, rdy pulse. Third RETI -> no rdy.
- isq_block_i=1 with a valid request at cm -> na, no acceptance. Next boundary with block=0 -> accepted.
- stack_ack delayed 3 cycles in PUSH_LO -> push_o and data=pc[7:0] held 4 cycles; hold stays high throughout; LOAD occurs exactly once.
- Reset asserted in PUSH_HI -> all outputs 0 asynchronously, lvl=00. After release, a new request is serviced normally. Also: vect=7 at cm -> na.
